lms_fir_engine: RTL and testbench

LMS_FIR_ENGINE -- requirements
Module: lms_fir_engine

---
 rtl/lms_pkg.sv | 41 ++++
 rtl/lms_mac.sv | 57 +++++
 rtl/lms_fir_engine.sv | 256 +++++++++++++++++++++++++
 tb/tb_lms_fir_engine.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lms_pkg.sv
// Shared definitions for the LMS adaptive FIR engine: FSM state encoding,
// default widths/shifts and the signed saturation helper.
package lms_pkg;

  localparam int X_W_DEF        = 16;
  localparam int E_W_DEF        = 16;
  localparam int W_W_DEF        = 16;
  localparam int TAPS_DEF       = 8;
  localparam int MU_SHIFT_DEF   = 12;
  localparam int LEAK_SHIFT_DEF = 10;

  // Width of the intermediate used for the coefficient update before clipping.
  localparam int SAT_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UPDATE = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_FILTER = 3'd3,
    ST_DONE   = 3'd4
  } lms_state_e;

  // Clip a wide signed value into the range of a w-bit two's complement number.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/lms_mac.sv
// Shared registered signed multiplier. During UPDATE it forms err*x[k] for the
// coefficient update; during SHIFT/FILTER it forms x[k]*w[k] for the output.
module lms_mac
  import lms_pkg::*;
#(
  parameter int A_W = 16,
  parameter int E_W = 16,
  parameter int W_W = 16,
  parameter int B_W = 16,
  parameter int P_W = A_W + B_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  lms_state_e            state,
  input  logic signed [A_W-1:0] upd_x,
  input  logic signed [E_W-1:0] upd_e,
  input  logic signed [A_W-1:0] flt_x,
  input  logic signed [W_W-1:0] flt_w,
  output logic signed [P_W-1:0] prod
);

  logic signed [A_W-1:0] a_s;
  logic signed [B_W-1:0] b_s;
  logic signed [P_W-1:0] prod_r;

  // Operand selection by engine phase.
  always_comb begin
    a_s = {A_W{1'b0}};
    b_s = {B_W{1'b0}};
    case (state)
      ST_UPDATE: begin
        a_s = upd_x;
        b_s = B_W'(upd_e);
      end
      ST_SHIFT, ST_FILTER: begin
        a_s = flt_x;
        b_s = B_W'(flt_w);
      end
      default: begin
        a_s = {A_W{1'b0}};
        b_s = {B_W{1'b0}};
      end
    endcase
  end

  // Product register: result is usable one cycle after the operands are selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r <= {P_W{1'b0}};
    end else begin
      prod_r <= a_s * b_s;
    end
  end

  assign prod = prod_r;

endmodule

// File: rtl/lms_fir_engine.sv
// Sequential LMS adaptive FIR engine. Per accepted sample: TAPS update cycles,
// one delay-line shift, TAPS filter cycles and one output cycle, all through a
// single shared multiplier (lms_mac).
// Optional build macro LMS_LEAKAGE_EN adds coefficient leakage w - (w >>> LEAK_SHIFT).
module lms_fir_engine
  import lms_pkg::*;
#(
  parameter int X_W      = X_W_DEF,
  parameter int E_W      = E_W_DEF,
  parameter int W_W      = W_W_DEF,
  parameter int TAPS     = TAPS_DEF,
  parameter int MU_SHIFT = MU_SHIFT_DEF,
`ifdef LMS_LEAKAGE_EN
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
`endif
  parameter int ACC_W    = X_W + W_W + $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [X_W-1:0]   xin,
  input  logic signed [E_W-1:0]   err,
  input  logic                    coef_clr,
  output logic signed [ACC_W-1:0] yout,
  output logic                    out_valid,
  output logic                    update
);

  localparam int CNT_W = $clog2(TAPS);
  localparam int B_W   = (E_W > W_W) ? E_W : W_W;
  localparam int P_W   = X_W + B_W;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(TAPS - 1);

  lms_state_e state_r, state_n;
  logic [CNT_W-1:0] k_r, k_n;

  logic signed [X_W-1:0]   x_r [TAPS];
  logic signed [W_W-1:0]   w_r [TAPS];
  logic signed [X_W-1:0]   xin_r;
  logic signed [E_W-1:0]   err_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] yout_r;
  logic                    in_ready_r, out_valid_r, update_r;
  logic                    out_valid_n, update_n;

  logic [CNT_W-1:0]        flt_k_s;
  logic signed [X_W-1:0]   flt_x_s;
  logic signed [W_W-1:0]   flt_w_s;
  logic signed [P_W-1:0]   prod_s;
  logic signed [ACC_W-1:0] prod_acc_s;

  logic                    wr_en_s;
  logic [CNT_W-1:0]        wr_idx_s;
  logic signed [W_W-1:0]   w_cur_s;
  logic signed [SAT_W-1:0] delta_s;
  logic signed [SAT_W-1:0] sum_s;
  logic signed [W_W-1:0]   w_next_s;

  // Next-state, tap counter and pulse decode for the sample sequencer.
  always_comb begin
    state_n     = state_r;
    k_n         = k_r;
    out_valid_n = 1'b0;
    update_n    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_n = ST_UPDATE;
          k_n     = {CNT_W{1'b0}};
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (k_r == LAST_K) begin
          state_n  = ST_SHIFT;
          k_n      = {CNT_W{1'b0}};
          update_n = 1'b1;
        end else begin
          k_n = k_r + CNT_W'(1'b1);
        end
      end
      ST_SHIFT: begin
        state_n = ST_FILTER;
        k_n     = {CNT_W{1'b0}};
      end
      ST_FILTER: begin
        if (k_r == LAST_K) begin
          state_n     = ST_DONE;
          k_n         = {CNT_W{1'b0}};
          out_valid_n = 1'b1;
        end else begin
          k_n = k_r + CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        k_n     = {CNT_W{1'b0}};
      end
      default: begin
        state_n = ST_IDLE;
        k_n     = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sequencer state and tap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      k_r     <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_n;
      k_r     <= k_n;
    end
  end

  // Handshake and pulse outputs, registered so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      update_r    <= 1'b0;
    end else begin
      in_ready_r  <= (state_n == ST_IDLE);
      out_valid_r <= out_valid_n;
      update_r    <= update_n;
    end
  end

  // Filter operands run one tap ahead because the multiplier is registered:
  // SHIFT feeds tap 0 (the new sample), FILTER cycle k feeds tap k+1.
  always_comb begin
    flt_k_s = {CNT_W{1'b0}};
    flt_x_s = {X_W{1'b0}};
    flt_w_s = {W_W{1'b0}};
    if (state_r == ST_SHIFT) begin
      flt_k_s = {CNT_W{1'b0}};
      flt_x_s = xin_r;
      flt_w_s = w_r[0];
    end else if (state_r == ST_FILTER) begin
      flt_k_s = (k_r == LAST_K) ? {CNT_W{1'b0}} : (k_r + CNT_W'(1'b1));
      flt_x_s = x_r[flt_k_s];
      flt_w_s = w_r[flt_k_s];
    end else begin
      flt_k_s = {CNT_W{1'b0}};
      flt_x_s = {X_W{1'b0}};
      flt_w_s = {W_W{1'b0}};
    end
  end

  lms_mac #(
    .A_W (X_W),
    .E_W (E_W),
    .W_W (W_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .state (state_r),
    .upd_x (x_r[k_r]),
    .upd_e (err_r),
    .flt_x (flt_x_s),
    .flt_w (flt_w_s),
    .prod  (prod_s)
  );

  assign prod_acc_s = ACC_W'(prod_s);

  // Coefficient update: the product for tap k lands one cycle later, so UPDATE
  // cycle k writes tap k-1 and SHIFT writes the last tap.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = {CNT_W{1'b0}};
    if ((state_r == ST_UPDATE) && (k_r != {CNT_W{1'b0}})) begin
      wr_en_s  = 1'b1;
      wr_idx_s = k_r - CNT_W'(1'b1);
    end else if (state_r == ST_SHIFT) begin
      wr_en_s  = 1'b1;
      wr_idx_s = LAST_K;
    end else begin
      wr_en_s  = 1'b0;
      wr_idx_s = {CNT_W{1'b0}};
    end
    w_cur_s = w_r[wr_idx_s];
    delta_s = SAT_W'(prod_s >>> MU_SHIFT);
`ifdef LMS_LEAKAGE_EN
    sum_s   = SAT_W'(w_cur_s) - SAT_W'(w_cur_s >>> LEAK_SHIFT) + delta_s;
`else
    sum_s   = SAT_W'(w_cur_s) + delta_s;
`endif
    w_next_s = W_W'(sat_signed(sum_s, W_W));
  end

  // Sample capture and delay line. A clear accepted together with a sample also
  // discards that sample's error, since it refers to the weights being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xin_r <= {X_W{1'b0}};
      err_r <= {E_W{1'b0}};
      for (int i = 0; i < TAPS; i++) begin
        x_r[i] <= {X_W{1'b0}};
      end
    end else begin
      if ((state_r == ST_IDLE) && in_valid) begin
        xin_r <= xin;
        err_r <= coef_clr ? {E_W{1'b0}} : err;
      end
      if (state_r == ST_SHIFT) begin
        for (int i = TAPS - 1; i > 0; i--) begin
          x_r[i] <= x_r[i-1];
        end
        x_r[0] <= xin_r;
      end
    end
  end

  // Coefficient storage: bulk clear while idle, otherwise one tap written per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        w_r[i] <= {W_W{1'b0}};
      end
    end else if ((state_r == ST_IDLE) && coef_clr) begin
      for (int i = 0; i < TAPS; i++) begin
        w_r[i] <= {W_W{1'b0}};
      end
    end else if (wr_en_s) begin
      w_r[wr_idx_s] <= w_next_s;
    end
  end

  // Output accumulator: cleared in SHIFT, summed during FILTER, result latched
  // on the last FILTER cycle so yout is valid together with out_valid in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= {ACC_W{1'b0}};
      yout_r <= {ACC_W{1'b0}};
    end else if (state_r == ST_SHIFT) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (state_r == ST_FILTER) begin
      acc_r <= acc_r + prod_acc_s;
      if (k_r == LAST_K) begin
        yout_r <= acc_r + prod_acc_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign update    = update_r;
  assign yout      = yout_r;

endmodule

// File: tb/tb_lms_fir_engine.sv
// Directed bench for lms_fir_engine at default parameters (TAPS=8, MU_SHIFT=12).
module tb_lms_fir_engine;

  localparam int ACC_W = 16 + 16 + 3;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [15:0]      xin;
  logic signed [15:0]      err;
  logic                    coef_clr;
  logic signed [ACC_W-1:0] yout;
  logic                    out_valid;
  logic                    update;

  int n_vec;
  int n_err;

  lms_fir_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xin       (xin),
    .err       (err),
    .coef_clr  (coef_clr),
    .yout      (yout),
    .out_valid (out_valid),
    .update    (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample: wait for in_ready, present it, then check latency, update
  // pulse count, yout and the handshake around the output pulse.
  task automatic send(input string tag, input logic signed [15:0] x_v,
                      input logic signed [15:0] e_v, input logic clr_v,
                      input logic signed [63:0] y_exp);
    int n;
    int lat;
    int upd_cnt;
    @(negedge clk);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'sd1);
    in_valid = 1'b1;
    xin      = x_v;
    err      = e_v;
    coef_clr = clr_v;
    lat = 0;
    upd_cnt = 0;
    n = 0;
    while (lat == 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        coef_clr = 1'b0;
        xin      = 16'sd0;
        err      = 16'sd0;
      end
      if (update === 1'b1) upd_cnt++;
      if (out_valid === 1'b1) lat = n;
    end
    check({tag, "_latency"}, 64'(lat), 64'sd18);
    check({tag, "_update_pulses"}, 64'(upd_cnt), 64'sd1);
    check({tag, "_yout"}, 64'(yout), y_exp);
    check({tag, "_busy_in_done"}, 64'(in_ready), 64'sd0);
    @(posedge clk);
    #1;
    check({tag, "_valid_one_cycle"}, 64'(out_valid), 64'sd0);
    check({tag, "_ready_after"}, 64'(in_ready), 64'sd1);
  endtask

  initial begin
    int n;
    int ov_cnt;
    int up_cnt;
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    xin      = 16'sd0;
    err      = 16'sd0;
    coef_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'sd1);
    check("rst_out_valid", 64'(out_valid), 64'sd0);
    check("rst_update", 64'(update), 64'sd0);
    check("rst_yout", 64'(yout), 64'sd0);

    // Zero error: no adaptation, output zero.
    send("s1_x1000", 16'sd1000, 16'sd0, 1'b0, 64'sd0);
    // w0 += 16384*1000 >>> 12 = 4000.
    send("s2_train_w0", 16'sd0, 16'sd16384, 1'b0, 64'sd0);
    send("s3_y8000", 16'sd2, 16'sd0, 1'b0, 64'sd8000);
    // Negative rounding toward -inf: w0 -> 3999, w2 -> -1.
    send("s4_floor", 16'sd0, -16'sd1, 1'b0, 64'sd0);
    send("s5_y11995", 16'sd3, 16'sd0, 1'b0, 64'sd11995);
    // Clear together with a sample: zero weights, yout 0.
    send("s6_clr", 16'sd5, 16'sd123, 1'b1, 64'sd0);
    for (int i = 0; i < 8; i++) begin
      send($sformatf("s7_flush%0d", i), 16'sd0, 16'sd0, 1'b0, 64'sd0);
    end
    // Positive saturation of w0 and w2, negative saturation of w4.
    send("s8_x30000", 16'sd30000, 16'sd0, 1'b0, 64'sd0);
    send("s9_sat_w0", 16'sd0, 16'sd32767, 1'b0, 64'sd0);
    send("s10_y32767", 16'sd1, 16'sd0, 1'b0, 64'sd32767);
    send("s11_sat_hold", 16'sd0, 16'sd16384, 1'b0, 64'sd0);
    send("s12_y65534", 16'sd1, 16'sd0, 1'b0, 64'sd65534);
    send("s13_neg_sat", 16'sd0, 16'sh8000, 1'b0, 64'sd0);
    send("s14_y65509", 16'sd2, 16'sd0, 1'b0, 64'sd65509);

    // Reset in the middle of FILTER: the sample must be dropped entirely.
    @(negedge clk);
    in_valid = 1'b1;
    xin      = 16'sd2;
    err      = 16'sd0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      xin      = 16'sd0;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'sd0);
    check("mid_rst_update", 64'(update), 64'sd0);
    check("mid_rst_yout", 64'(yout), 64'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ready_next", 64'(in_ready), 64'sd1);
    ov_cnt = 0;
    up_cnt = 0;
    for (n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) ov_cnt++;
      if (update !== 1'b0) up_cnt++;
    end
    check("mid_rst_no_out_pulse", 64'(ov_cnt), 64'sd0);
    check("mid_rst_no_update_pulse", 64'(up_cnt), 64'sd0);
    // Weights were nonzero before reset; zero output proves they were cleared.
    send("s15_after_rst", 16'sd7, 16'sd0, 1'b0, 64'sd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
